dram_port_arbiter: RTL
======================

Name: dram_port_arbiter

Overview:
- Shares the single-port data RAM (d_ram) between two requesters: the CPU memory-access stage and a debug/monitor port. The debug port is used by the display and system-view logic to read or patch data memory while a program runs.
- Sits between memory_access_d_ram and d_ram. The CPU has fixed priority; a starvation counter guarantees the debug port a slot.
- Read data is tagged and routed back to its requester after the RAM read latency.

Parameters:
- AW, 15, word address width
- DW, 16, data width
- RD_LAT, 1, d_ram read latency in cycles (1..3)
- STARVE_MAX, 8, consecutive cycles a pending debug request may be denied before a forced grant

Ports:
- clk  in  1  system clock (the single clock of this block)
- init_n  in  1  synchronous active-low reset
- cpu_req  in  1  CPU access valid this cycle
- cpu_we  in  1  CPU write enable
- cpu_addr  in  AW  CPU word address
- cpu_wdata  in  DW  CPU write data
- cpu_stall  out  1  CPU access not performed this cycle; pipeline must hold
- cpu_rvalid  out  1  CPU read data valid
- cpu_rdata  out  DW  CPU read data
- dbg_req  in  1  debug request, held until granted
- dbg_we  in  1  debug write enable
- dbg_addr  in  AW  debug word address
- dbg_wdata  in  DW  debug write data
- dbg_gnt  out  1  debug request accepted this cycle
- dbg_rvalid  out  1  debug read data valid
- dbg_rdata  out  DW  debug read data
- ram_addr  out  AW  to d_ram address
- ram_wren  out  1  to d_ram write enable
- ram_data  out  DW  to d_ram write data
- ram_q  in  DW  from d_ram read data

Behaviour:
- Reset (init_n=0 at posedge clk):
  - State goes to ARB; starve_cnt=0; the tag pipe is cleared.
  - All outputs read 0: rvalids, dbg_gnt, cpu_stall, ram_wren, ram_addr, ram_data.
  - Reset mid-read drops the in-flight read; no rvalid is ever emitted for it.
- Grant is decided combinationally from the current request inputs and the registered state.
- ram_addr, ram_wren and ram_data are driven combinationally from the granted requester. When nothing is granted they are 0 (ram_wren=0).
- FSM states: ARB, FORCE.
- ARB state:
  - cpu_req=1: CPU granted, cpu_stall=0.
  - cpu_req=0 and dbg_req=1: debug granted, dbg_gnt=1.
  - If dbg_req=1 and the debug port is denied: starve_cnt increments, saturating at STARVE_MAX.
  - If starve_cnt reaches STARVE_MAX-1 while the debug port is still denied: next state is FORCE.
  - A debug grant clears starve_cnt to 0.
  - dbg_req=0 clears starve_cnt to 0.
- FORCE state (exactly one cycle):
  - Debug granted, dbg_gnt=1.
  - If cpu_req=1 that cycle: cpu_stall=1 and the CPU access is not performed.
  - Next state is ARB; starve_cnt=0.
  - If dbg_req has dropped by then (illegal, but handled): no grant, cpu_stall=0, return to ARB.
- cpu_stall is only ever 1 in FORCE with cpu_req=1. A stalled CPU re-presents the same request the next cycle; that request is granted, because ARB gives the CPU priority.
- Reads:
  - A granted read pushes a tag {valid, owner} into an RD_LAT-deep shift register.
  - When the tag exits the register: the owner's rvalid=1 for one cycle, and its rdata=ram_q.
  - Non-owner rdata holds its last value.
  - Writes push an invalid tag and produce no rvalid.
- Back-to-back reads (one per cycle, any mix of owners) are supported with full throughput and in-order returns.
- Simultaneous cpu_req and dbg_req in ARB with starve_cnt below threshold: CPU wins, debug waits.

Decomposition:
- Package xm23_mem_pkg holds:
  - typedef owner_e {OWN_CPU, OWN_DBG}
  - typedef arb_state_e {ARB, FORCE}
  - struct rd_tag_t {logic valid; owner_e owner;}
  - AW/DW defaults
- One sub-module: rd_tag_pipe, the RD_LAT-deep tag shift register with synchronous active-low reset.

Test Plan:
- Reset: hold init_n=0 with cpu_req=1 and dbg_req=1 -> all outputs 0. Release, then CPU read addr 0x0010 returning 0xBEEF -> cpu_rvalid=1 with cpu_rdata=0xBEEF exactly RD_LAT cycles after grant; dbg_rvalid stays 0.
- Idle CPU: cpu_req=0, dbg write addr 0x7000 data 0x1234 -> same cycle dbg_gnt=1, ram_wren=1, ram_addr=0x7000, ram_data=0x1234; no rvalid.
- Starvation: cpu_req=1 continuously and dbg_req=1 from cycle 0, STARVE_MAX=8 -> dbg_gnt=1 and cpu_stall=1 in cycle 8 only. The CPU access is then performed in cycle 9.
- Mixed back-to-back reads: CPU 0x0001, then debug in a FORCE slot 0x0002, then CPU 0x0003, with RAM returning 0xA1/0xA2/0xA3 -> rvalids in order CPU, DBG, CPU with matching data, one per cycle.
- Reset mid-read: grant a CPU read, then assert init_n=0 one cycle later -> no cpu_rvalid ever appears for that read; starve_cnt is 0 after reset.
- Early drop in FORCE: dbg_req drops on the FORCE cycle -> dbg_gnt=0, cpu_stall=0, CPU granted, state returns to ARB.

Source files
------------

// File: rtl/xm23_mem_pkg.sv
// Shared types for the data-RAM port arbiter: requester identity, arbiter
// states and the read tag that follows a read through the RAM latency.
package xm23_mem_pkg;

    localparam int AW_DEF = 15;
    localparam int DW_DEF = 16;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } owner_e;

    typedef enum logic {
        ARB   = 1'b0,
        FORCE = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
    } rd_tag_t;

    localparam rd_tag_t TAG_NONE = '{valid: 1'b0, owner: OWN_CPU};

endpackage

// File: rtl/rd_tag_pipe.sv
// Fixed-depth shift register carrying one read tag per cycle, so each read
// result can be routed back to its requester when the RAM data appears.
module rd_tag_pipe
    import xm23_mem_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic    clk,
    input  logic    init_n,
    input  rd_tag_t tag_in,
    output rd_tag_t tag_out
);

    rd_tag_t stage [DEPTH];

    // Shift tags one stage per cycle; reset empties the pipe.
    always_ff @(posedge clk) begin
        // NOTE: the tag stages are reset (unlike the RAM array itself) so that a
        // read in flight across a reset can never surface as a stray rvalid.
        if (!init_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= TAG_NONE;
            end
        end else begin
            // NOTE: non-blocking assignments make every stage sample the old value
            // of its neighbour, which is what turns this loop into a shift register.
            stage[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/dram_port_arbiter.sv
// Shares the single-port data RAM between the CPU memory-access stage and the
// debug/monitor port. The CPU has fixed priority; a starvation counter forces
// a one-cycle debug slot after STARVE_MAX consecutive denials.
module dram_port_arbiter
    import xm23_mem_pkg::*;
#(
    parameter int AW         = AW_DEF,
    parameter int DW         = DW_DEF,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 8
) (
    input  logic          clk,
    input  logic          init_n,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_stall,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_gnt,
    output logic          dbg_rvalid,
    output logic [DW-1:0] dbg_rdata,
    output logic [AW-1:0] ram_addr,
    output logic          ram_wren,
    output logic [DW-1:0] ram_data,
    input  logic [DW-1:0] ram_q
);

    localparam int CW = $clog2(STARVE_MAX + 1);

    arb_state_e    state_q, state_d;
    logic [CW-1:0] starve_q, starve_d;
    logic          cpu_gnt;
    rd_tag_t       tag_in, tag_out;
    logic [DW-1:0] cpu_rdata_q, dbg_rdata_q;

    // Arbitration: grants, stall and next state/counter from requests and state.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path through
        // the case/if tree can leave a signal unassigned and infer a latch.
        state_d   = ARB;
        starve_d  = '0;
        cpu_gnt   = 1'b0;
        dbg_gnt   = 1'b0;
        cpu_stall = 1'b0;
        if (init_n) begin
            unique case (state_q)
                ARB: begin
                    if (cpu_req) begin
                        cpu_gnt = 1'b1;
                        if (dbg_req) begin
                            // Debug denied this cycle: count it, and force a slot
                            // once the denial streak reaches STARVE_MAX.
                            if (starve_q == CW'(STARVE_MAX - 1)) begin
                                state_d = FORCE;
                            end
                            if (starve_q != CW'(STARVE_MAX)) begin
                                starve_d = starve_q + CW'(1);
                            end else begin
                                starve_d = starve_q;
                            end
                        end
                    end else if (dbg_req) begin
                        dbg_gnt = 1'b1;
                    end
                end
                FORCE: begin
                    if (dbg_req) begin
                        dbg_gnt   = 1'b1;
                        cpu_stall = cpu_req;
                    end else begin
                        // Debug withdrew its request: the slot goes back to the CPU.
                        cpu_gnt = cpu_req;
                    end
                end
            endcase
        end
    end

    // State and starvation counter registers.
    always_ff @(posedge clk) begin
        if (!init_n) begin
            state_q  <= ARB;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    // RAM port mux and read-tag generation for the granted requester.
    always_comb begin
        ram_addr = '0;
        ram_wren = 1'b0;
        ram_data = '0;
        tag_in   = TAG_NONE;
        if (cpu_gnt) begin
            ram_addr = cpu_addr;
            ram_wren = cpu_we;
            ram_data = cpu_wdata;
            tag_in   = '{valid: !cpu_we, owner: OWN_CPU};
        end else if (dbg_gnt) begin
            ram_addr = dbg_addr;
            ram_wren = dbg_we;
            ram_data = dbg_wdata;
            tag_in   = '{valid: !dbg_we, owner: OWN_DBG};
        end
    end

    rd_tag_pipe #(
        .DEPTH (RD_LAT)
    ) u_rd_tag_pipe (
        .clk     (clk),
        .init_n  (init_n),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    // A tag leaving the pipe lines up with ram_q; route it to its owner.
    assign cpu_rvalid = init_n && tag_out.valid && (tag_out.owner == OWN_CPU);
    assign dbg_rvalid = init_n && tag_out.valid && (tag_out.owner == OWN_DBG);

    // Capture returned data so each port's rdata holds between its own returns.
    always_ff @(posedge clk) begin
        if (!init_n) begin
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            if (cpu_rvalid) begin
                cpu_rdata_q <= ram_q;
            end
            if (dbg_rvalid) begin
                dbg_rdata_q <= ram_q;
            end
        end
    end

    assign cpu_rdata = cpu_rvalid ? ram_q : cpu_rdata_q;
    assign dbg_rdata = dbg_rvalid ? ram_q : dbg_rdata_q;

endmodule
